// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with RAW forwarding from MEM/WB, operand source selection and load-use bubble insertion.
// Latency: one cycle decode->ALU operands; backpressure: ex_stall holds the EX register, load_use_stall holds fetch/decode.
module ex_operand_stage #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [5:0]        id_ex_type,
    input  logic [REG_AW-1:0] id_rs1_addr,
    input  logic [REG_AW-1:0] id_rs2_addr,
    input  logic              id_rs1_used,
    input  logic              id_rs2_used,
    input  logic [XLEN-1:0]   id_rs1_data,
    input  logic [XLEN-1:0]   id_rs2_data,
    input  logic [XLEN-1:0]   id_imm,
    input  logic [XLEN-1:0]   id_pc,
    input  logic              id_use_imm,
    input  logic              id_use_pc,
    input  logic [REG_AW-1:0] id_rd_addr,
    input  logic              id_reg_write,
    input  logic              id_is_load,
    input  logic              mem_fwd_en,
    input  logic [REG_AW-1:0] mem_fwd_rd,
    input  logic [XLEN-1:0]   mem_fwd_data,
    input  logic              wb_fwd_en,
    input  logic [REG_AW-1:0] wb_fwd_rd,
    input  logic [XLEN-1:0]   wb_fwd_data,
    input  logic              ex_stall,
    input  logic              flush,
    output logic              ex_valid,
    output logic [5:0]        ex_ex_type,
    output logic [XLEN-1:0]   operand1,
    output logic [XLEN-1:0]   operand2,
    output logic [REG_AW-1:0] ex_rd_addr,
    output logic              ex_reg_write,
    output logic              ex_is_load,
    output logic              load_use_stall
);

    logic              r_valid;
    logic [5:0]        r_type;
    logic [REG_AW-1:0] r_rs1_addr, r_rs2_addr, r_rd;
    logic [XLEN-1:0]   r_rs1_data, r_rs2_data, r_imm, r_pc;
    logic              r_use_imm, r_use_pc, r_rw, r_ld;

    logic              ld_hit_rs1, ld_hit_rs2;
    logic              wb_held_rs1, wb_held_rs2;
    logic [XLEN-1:0]   fwd_rs1, fwd_rs2, sel2;
    logic              is_shift;

    assign ld_hit_rs1     = id_rs1_used && (id_rs1_addr == r_rd);
    assign ld_hit_rs2     = id_rs2_used && (id_rs2_addr == r_rd);
    assign load_use_stall = id_valid && r_valid && r_ld && (r_rd != '0) && (ld_hit_rs1 || ld_hit_rs2);

    // WB retiring into a held source register must be captured, or it is lost once WB moves on.
    assign wb_held_rs1 = wb_fwd_en && (wb_fwd_rd != '0) && (wb_fwd_rd == r_rs1_addr);
    assign wb_held_rs2 = wb_fwd_en && (wb_fwd_rd != '0) && (wb_fwd_rd == r_rs2_addr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid    <= 1'b0;
            r_type     <= '0;
            r_rs1_addr <= '0;
            r_rs2_addr <= '0;
            r_rd       <= '0;
            r_rs1_data <= '0;
            r_rs2_data <= '0;
            r_imm      <= '0;
            r_pc       <= '0;
            r_use_imm  <= 1'b0;
            r_use_pc   <= 1'b0;
            r_rw       <= 1'b0;
            r_ld       <= 1'b0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (ex_stall) begin
            if (wb_held_rs1) r_rs1_data <= wb_fwd_data;
            if (wb_held_rs2) r_rs2_data <= wb_fwd_data;
        end else if (load_use_stall) begin
            r_valid <= 1'b0;
        end else begin
            r_valid    <= id_valid;
            r_type     <= id_ex_type;
            r_rs1_addr <= id_rs1_addr;
            r_rs2_addr <= id_rs2_addr;
            r_rd       <= id_rd_addr;
            r_rs1_data <= id_rs1_data;
            r_rs2_data <= id_rs2_data;
            r_imm      <= id_imm;
            r_pc       <= id_pc;
            r_use_imm  <= id_use_imm;
            r_use_pc   <= id_use_pc;
            r_rw       <= id_reg_write;
            r_ld       <= id_is_load;
        end
    end

    // MEM is younger than WB, so it wins; x0 is never forwarded.
    always_comb begin
        fwd_rs1 = r_rs1_data;
        if (mem_fwd_en && (mem_fwd_rd != '0) && (mem_fwd_rd == r_rs1_addr))
            fwd_rs1 = mem_fwd_data;
        else if (wb_fwd_en && (wb_fwd_rd != '0) && (wb_fwd_rd == r_rs1_addr))
            fwd_rs1 = wb_fwd_data;
    end

    always_comb begin
        fwd_rs2 = r_rs2_data;
        if (mem_fwd_en && (mem_fwd_rd != '0) && (mem_fwd_rd == r_rs2_addr))
            fwd_rs2 = mem_fwd_data;
        else if (wb_fwd_en && (wb_fwd_rd != '0) && (wb_fwd_rd == r_rs2_addr))
            fwd_rs2 = wb_fwd_data;
    end

    assign is_shift = (r_type >= 6'd9) && (r_type <= 6'd14);
    assign sel2     = r_use_imm ? r_imm : fwd_rs2;

    assign operand1 = r_use_pc ? r_pc : fwd_rs1;
    assign operand2 = is_shift ? {{(XLEN-5){1'b0}}, sel2[4:0]} : sel2;

    assign ex_valid     = r_valid;
    assign ex_ex_type   = r_type;
    assign ex_rd_addr   = r_rd;
    assign ex_reg_write = r_valid && r_rw;
    assign ex_is_load   = r_valid && r_ld;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Bench for ex_operand_stage: table of decode vectors with a scoreboard queue, plus hand-written hazard/stall/flush/reset sequences.
module tb_ex_operand_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic [5:0]  id_ex_type;
    logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
    logic        id_rs1_used, id_rs2_used;
    logic [31:0] id_rs1_data, id_rs2_data, id_imm, id_pc;
    logic        id_use_imm, id_use_pc, id_reg_write, id_is_load;
    logic        mem_fwd_en, wb_fwd_en;
    logic [4:0]  mem_fwd_rd, wb_fwd_rd;
    logic [31:0] mem_fwd_data, wb_fwd_data;
    logic        ex_stall, flush;
    logic        ex_valid, ex_reg_write, ex_is_load, load_use_stall;
    logic [5:0]  ex_ex_type;
    logic [31:0] operand1, operand2;
    logic [4:0]  ex_rd_addr;

    int checks   = 0;
    int failures = 0;

    ex_operand_stage #(.XLEN(32), .REG_AW(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_ex_type(id_ex_type),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
        .id_imm(id_imm), .id_pc(id_pc),
        .id_use_imm(id_use_imm), .id_use_pc(id_use_pc),
        .id_rd_addr(id_rd_addr), .id_reg_write(id_reg_write), .id_is_load(id_is_load),
        .mem_fwd_en(mem_fwd_en), .mem_fwd_rd(mem_fwd_rd), .mem_fwd_data(mem_fwd_data),
        .wb_fwd_en(wb_fwd_en), .wb_fwd_rd(wb_fwd_rd), .wb_fwd_data(wb_fwd_data),
        .ex_stall(ex_stall), .flush(flush),
        .ex_valid(ex_valid), .ex_ex_type(ex_ex_type),
        .operand1(operand1), .operand2(operand2),
        .ex_rd_addr(ex_rd_addr), .ex_reg_write(ex_reg_write),
        .ex_is_load(ex_is_load), .load_use_stall(load_use_stall)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [5:0]  typ;
        logic [4:0]  rs1a;
        logic [31:0] rs1d;
        logic [4:0]  rs2a;
        logic [31:0] rs2d;
        logic [31:0] imm, pc;
        logic        uimm, upc;
        logic [4:0]  rd;
        logic        rw, ld;
        logic        men;
        logic [4:0]  mrd;
        logic [31:0] mdat;
        logic        wen;
        logic [4:0]  wrd;
        logic [31:0] wdat;
        logic [31:0] e1, e2;
    } vec_t;

    typedef struct {
        logic        valid;
        logic [5:0]  typ;
        logic [4:0]  rd;
        logic        rw, ld;
        logic [31:0] op1, op2;
    } exp_t;

    vec_t tbl[14];
    exp_t sbq[$];

    function automatic vec_t mk(input logic v, input logic [5:0] t,
                                input logic [4:0] a1, input logic [31:0] d1,
                                input logic [4:0] a2, input logic [31:0] d2,
                                input logic [31:0] im, input logic [31:0] p,
                                input logic ui, input logic up,
                                input logic [4:0] rd, input logic rw, input logic ld,
                                input logic me, input logic [4:0] mr, input logic [31:0] md,
                                input logic we, input logic [4:0] wr, input logic [31:0] wd,
                                input logic [31:0] e1, input logic [31:0] e2);
        vec_t r;
        r.valid = v; r.typ = t; r.rs1a = a1; r.rs1d = d1; r.rs2a = a2; r.rs2d = d2;
        r.imm = im; r.pc = p; r.uimm = ui; r.upc = up; r.rd = rd; r.rw = rw; r.ld = ld;
        r.men = me; r.mrd = mr; r.mdat = md; r.wen = we; r.wrd = wr; r.wdat = wd;
        r.e1 = e1; r.e2 = e2;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic idle_id();
        id_valid = 0; id_ex_type = 0; id_rs1_addr = 0; id_rs2_addr = 0;
        id_rs1_used = 0; id_rs2_used = 0; id_rs1_data = 0; id_rs2_data = 0;
        id_imm = 0; id_pc = 0; id_use_imm = 0; id_use_pc = 0;
        id_rd_addr = 0; id_reg_write = 0; id_is_load = 0;
    endtask

    task automatic no_fwd();
        mem_fwd_en = 0; mem_fwd_rd = 0; mem_fwd_data = 0;
        wb_fwd_en = 0; wb_fwd_rd = 0; wb_fwd_data = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_vec(input vec_t v);
        id_valid = v.valid; id_ex_type = v.typ;
        id_rs1_addr = v.rs1a; id_rs1_data = v.rs1d; id_rs1_used = 1'b1;
        id_rs2_addr = v.rs2a; id_rs2_data = v.rs2d; id_rs2_used = 1'b1;
        id_imm = v.imm; id_pc = v.pc; id_use_imm = v.uimm; id_use_pc = v.upc;
        id_rd_addr = v.rd; id_reg_write = v.rw; id_is_load = v.ld;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        // Reset with unknown inputs
        rst_n = 0; ex_stall = 1'bx; flush = 1'bx;
        id_valid = 'x; id_ex_type = 'x; id_rs1_addr = 'x; id_rs2_addr = 'x;
        id_rs1_used = 'x; id_rs2_used = 'x; id_rs1_data = 'x; id_rs2_data = 'x;
        id_imm = 'x; id_pc = 'x; id_use_imm = 'x; id_use_pc = 'x;
        id_rd_addr = 'x; id_reg_write = 'x; id_is_load = 'x;
        no_fwd();
        #12;
        chk("rst_ex_valid", {31'b0, ex_valid}, 0);
        chk("rst_reg_write", {31'b0, ex_reg_write}, 0);
        chk("rst_is_load", {31'b0, ex_is_load}, 0);
        chk("rst_ex_type", {26'b0, ex_ex_type}, 0);
        chk("rst_rd_addr", {27'b0, ex_rd_addr}, 0);
        chk("rst_load_use", {31'b0, load_use_stall}, 0);
        idle_id(); ex_stall = 0; flush = 0;
        #1;
        chk("rst_operand1", operand1, 0);
        chk("rst_operand2", operand2, 0);
        rst_n = 1;
        #1;
        chk("post_rst_load_use", {31'b0, load_use_stall}, 0);

        tbl[0]  = mk(1, 0,  1, 5, 2, 6, 0, 0, 0, 0, 10, 1, 0, 0, 0, 0, 0, 0, 0, 5, 6);
        tbl[1]  = mk(1, 0,  3, 32'h11, 3, 32'h11, 0, 0, 0, 0, 11, 1, 0,
                     1, 3, 32'hAAAA, 1, 3, 32'hBBBB, 32'hAAAA, 32'hAAAA);
        tbl[2]  = mk(1, 1,  3, 32'h11, 4, 32'h22, 0, 0, 0, 0, 12, 1, 0,
                     1, 4, 32'hCCCC, 1, 3, 32'hBBBB, 32'hBBBB, 32'hCCCC);
        tbl[3]  = mk(1, 0,  0, 0, 0, 0, 0, 0, 0, 0, 13, 1, 0,
                     1, 0, 32'hDEAD, 1, 0, 32'hBEEF, 0, 0);
        tbl[4]  = mk(1, 10, 1, 7, 0, 0, 32'h25, 0, 1, 0, 14, 1, 0, 0, 0, 0, 0, 0, 0, 7, 5);
        tbl[5]  = mk(1, 13, 1, 32'h80000000, 2, 32'hFFFFFFE1, 0, 0, 0, 0, 15, 1, 0,
                     0, 0, 0, 0, 0, 0, 32'h80000000, 1);
        tbl[6]  = mk(1, 20, 1, 32'h99, 0, 0, 32'h2000, 32'h100, 1, 1, 16, 1, 0,
                     0, 0, 0, 0, 0, 0, 32'h100, 32'h2000);
        tbl[7]  = mk(1, 19, 5, 32'h55, 0, 0, 32'hABCDE000, 32'h40, 1, 0, 17, 1, 0,
                     0, 0, 0, 0, 0, 0, 32'h55, 32'hABCDE000);
        tbl[8]  = mk(1, 9,  1, 3, 2, 32'h21, 0, 0, 0, 0, 18, 1, 0, 0, 0, 0, 0, 0, 0, 3, 1);
        tbl[9]  = mk(1, 8,  1, 3, 2, 32'h21, 0, 0, 0, 0, 18, 1, 0, 0, 0, 0, 0, 0, 0, 3, 32'h21);
        tbl[10] = mk(1, 14, 1, 3, 0, 0, 32'h3F, 0, 1, 0, 19, 1, 0, 0, 0, 0, 0, 0, 0, 3, 32'h1F);
        tbl[11] = mk(1, 15, 1, 3, 2, 32'hFFFFFFE1, 0, 0, 0, 0, 19, 0, 0,
                     0, 0, 0, 0, 0, 0, 3, 32'hFFFFFFE1);
        tbl[12] = mk(1, 0,  2, 1, 6, 2, 32'h30, 0, 1, 0, 20, 1, 0,
                     1, 6, 32'hEEEE, 0, 0, 0, 1, 32'h30);
        tbl[13] = mk(0, 2,  1, 9, 2, 8, 0, 0, 0, 0, 21, 1, 1, 0, 0, 0, 0, 0, 0, 9, 8);

        foreach (tbl[i]) begin
            no_fwd();
            drive_vec(tbl[i]);
            e.valid = tbl[i].valid; e.typ = tbl[i].typ; e.rd = tbl[i].rd;
            e.rw = tbl[i].valid & tbl[i].rw; e.ld = tbl[i].valid & tbl[i].ld;
            e.op1 = tbl[i].e1; e.op2 = tbl[i].e2;
            sbq.push_back(e);
            tick();
            mem_fwd_en = tbl[i].men; mem_fwd_rd = tbl[i].mrd; mem_fwd_data = tbl[i].mdat;
            wb_fwd_en = tbl[i].wen; wb_fwd_rd = tbl[i].wrd; wb_fwd_data = tbl[i].wdat;
            #1;
            if (sbq.size() == 0) begin
                checks++; failures++;
                $display("FAIL scoreboard_empty vec=%0d", i);
            end else begin
                e = sbq.pop_front();
                chk($sformatf("v%0d_valid", i), {31'b0, ex_valid}, {31'b0, e.valid});
                chk($sformatf("v%0d_type", i), {26'b0, ex_ex_type}, {26'b0, e.typ});
                chk($sformatf("v%0d_rd", i), {27'b0, ex_rd_addr}, {27'b0, e.rd});
                chk($sformatf("v%0d_rw", i), {31'b0, ex_reg_write}, {31'b0, e.rw});
                chk($sformatf("v%0d_ld", i), {31'b0, ex_is_load}, {31'b0, e.ld});
                chk($sformatf("v%0d_op1", i), operand1, e.op1);
                chk($sformatf("v%0d_op2", i), operand2, e.op2);
            end
        end
        no_fwd(); idle_id();
        tick();

        // Load to x0 never stalls
        id_valid = 1; id_rs1_addr = 1; id_rs1_used = 1; id_rd_addr = 0; id_is_load = 1; id_reg_write = 1;
        tick();
        idle_id(); id_valid = 1; id_rs1_addr = 0; id_rs1_used = 1; id_rs2_addr = 0; id_rs2_used = 1;
        #1;
        chk("lu_x0_no_stall", {31'b0, load_use_stall}, 0);

        // Load x7 followed by a dependent add
        idle_id();
        id_valid = 1; id_rs1_addr = 1; id_rs1_used = 1; id_rd_addr = 7; id_is_load = 1; id_reg_write = 1;
        tick();
        chk("lu_load_in_ex", {31'b0, ex_is_load}, 1);
        idle_id();
        id_valid = 1; id_rs1_addr = 2; id_rs1_data = 2; id_rs1_used = 1;
        id_rs2_addr = 7; id_rs2_data = 0; id_rs2_used = 0; id_rd_addr = 8; id_reg_write = 1;
        #1;
        chk("lu_unused_no_stall", {31'b0, load_use_stall}, 0);
        id_rs2_used = 1;
        #1;
        chk("lu_stall_asserted", {31'b0, load_use_stall}, 1);
        tick();
        chk("lu_bubble_valid", {31'b0, ex_valid}, 0);
        chk("lu_bubble_is_load", {31'b0, ex_is_load}, 0);
        chk("lu_stall_dropped", {31'b0, load_use_stall}, 0);
        tick();
        chk("lu_add_valid", {31'b0, ex_valid}, 1);
        chk("lu_add_rd", {27'b0, ex_rd_addr}, 8);
        mem_fwd_en = 1; mem_fwd_rd = 7; mem_fwd_data = 32'h777;
        #1;
        chk("lu_add_op1", operand1, 2);
        chk("lu_add_op2_fwd", operand2, 32'h777);
        no_fwd(); idle_id();

        // Stall for three cycles while WB retires x4
        id_valid = 1; id_rs1_addr = 1; id_rs1_data = 1; id_rs1_used = 1;
        id_rs2_addr = 4; id_rs2_data = 0; id_rs2_used = 1; id_rd_addr = 9; id_reg_write = 1;
        tick();
        ex_stall = 1;
        id_rs1_addr = 2; id_rs1_data = 32'h5A5A; id_rs2_addr = 3; id_rs2_data = 0; id_rd_addr = 21;
        wb_fwd_en = 1; wb_fwd_rd = 4; wb_fwd_data = 32'h1234;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk($sformatf("stall_hold_rd_c%0d", c), {27'b0, ex_rd_addr}, 9);
        end
        wb_fwd_en = 0; wb_fwd_data = 0; ex_stall = 0;
        #1;
        chk("stall_release_valid", {31'b0, ex_valid}, 1);
        chk("stall_release_op1", operand1, 1);
        chk("stall_refresh_op2", operand2, 32'h1234);
        tick();
        chk("stall_next_rd", {27'b0, ex_rd_addr}, 21);
        chk("stall_next_op1", operand1, 32'h5A5A);

        // Flush beats stall with a valid instruction waiting in ID
        ex_stall = 1; flush = 1;
        tick();
        chk("flush_valid", {31'b0, ex_valid}, 0);
        chk("flush_reg_write", {31'b0, ex_reg_write}, 0);
        ex_stall = 0; flush = 0;

        // auipc after flush, then asynchronous reset mid-operation
        idle_id();
        id_valid = 1; id_ex_type = 20; id_pc = 32'h100; id_imm = 32'h2000;
        id_use_pc = 1; id_use_imm = 1; id_rd_addr = 22; id_reg_write = 1;
        tick();
        chk("auipc_valid", {31'b0, ex_valid}, 1);
        chk("auipc_op1", operand1, 32'h100);
        chk("auipc_op2", operand2, 32'h2000);
        #2;
        rst_n = 0;
        #1;
        chk("midrst_valid", {31'b0, ex_valid}, 0);
        chk("midrst_rd", {27'b0, ex_rd_addr}, 0);
        chk("midrst_reg_write", {31'b0, ex_reg_write}, 0);
        chk("midrst_op1", operand1, 0);
        chk("midrst_op2", operand2, 0);
        #1;
        rst_n = 1;
        idle_id();
        tick();
        chk("post_midrst_valid", {31'b0, ex_valid}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
